// File: rtl/fetch_ctrl.sv
// Fetch/sequencing controller: drives PC load/increment, latches instructions from ROM,
// resolves jumps, branches and CALL/RET, and hands other opcodes to the execution unit.
module fetch_ctrl #(
    parameter int STACK_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  PC,
    input  logic [15:0] instr,
    input  logic        ZERO,
    input  logic        EXEC_DONE,
    output logic [7:0]  addr,
    output logic        LOAD_PC,
    output logic        INCR_PC,
    output logic [15:0] IR,
    output logic        EXEC_START,
    output logic        HALTED,
    output logic        FAULT
);

    localparam int CW = $clog2(STACK_DEPTH + 1);
    localparam int PW = $clog2(STACK_DEPTH);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_next;
    logic [CW-1:0] count;
    logic          exec_busy;
    logic          push;
    logic          pop;
    logic          fault_set;
    logic          stack_full;
    logic          stack_empty;
    logic [PW-1:0] wr_idx;
    logic [PW-1:0] rd_idx;
    logic [7:0]    stack [STACK_DEPTH];

    assign stack_full  = (count == CW'(STACK_DEPTH));
    assign stack_empty = (count == '0);
    assign wr_idx      = PW'(count);
    assign rd_idx      = PW'(count - CW'(1));

    always_comb begin
        state_next = state;
        addr       = '0;
        LOAD_PC    = 1'b0;
        INCR_PC    = 1'b0;
        EXEC_START = 1'b0;
        HALTED     = 1'b0;
        push       = 1'b0;
        pop        = 1'b0;
        fault_set  = 1'b0;
        case (state)
            S_FETCH: state_next = S_LOAD;
            S_LOAD:  state_next = S_DECODE;
            S_DECODE: begin
                state_next = S_FETCH;
                case (IR[15:12])
                    4'h0: INCR_PC = 1'b1;
                    4'h1: begin
                        addr    = IR[7:0];
                        LOAD_PC = 1'b1;
                    end
                    4'h2: begin
                        if (ZERO) begin
                            addr    = IR[7:0];
                            LOAD_PC = 1'b1;
                        end else begin
                            INCR_PC = 1'b1;
                        end
                    end
                    4'h3: begin
                        if (!ZERO) begin
                            addr    = IR[7:0];
                            LOAD_PC = 1'b1;
                        end else begin
                            INCR_PC = 1'b1;
                        end
                    end
                    4'h4: begin
                        if (stack_full) begin
                            fault_set  = 1'b1;
                            state_next = S_STOP;
                        end else begin
                            push    = 1'b1;
                            addr    = IR[7:0];
                            LOAD_PC = 1'b1;
                        end
                    end
                    4'h5: begin
                        if (stack_empty) begin
                            fault_set  = 1'b1;
                            state_next = S_STOP;
                        end else begin
                            pop     = 1'b1;
                            addr    = stack[rd_idx];
                            LOAD_PC = 1'b1;
                        end
                    end
                    4'hF:    state_next = S_STOP;
                    default: state_next = S_EXEC;
                endcase
            end
            S_EXEC: begin
                // exec_busy is clear only in the first EXEC cycle
                EXEC_START = !exec_busy;
                if (EXEC_DONE) begin
                    INCR_PC    = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_STOP:  HALTED = 1'b1;
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            IR        <= '0;
            count     <= '0;
            FAULT     <= 1'b0;
            exec_busy <= 1'b0;
        end else begin
            state     <= state_next;
            exec_busy <= (state == S_EXEC);
            if (state == S_LOAD) begin
                IR <= instr;
            end
            if (push) begin
                count <= count + CW'(1);
            end else if (pop) begin
                count <= count - CW'(1);
            end
            if (fault_set) begin
                FAULT <= 1'b1;
            end
        end
    end

    // Return addresses survive reset; only the count is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            stack[wr_idx] <= PC + 8'd1;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: external PC register and synchronous ROM, with an
// instruction-level reference model checked against directed and random programs.
module tb_fetch_ctrl;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pc_bus;
    logic [15:0] instr;
    logic        ZERO = 1'b0;
    logic        EXEC_DONE = 1'b0;
    logic [7:0]  addr;
    logic        LOAD_PC;
    logic        INCR_PC;
    logic [15:0] IR;
    logic        EXEC_START;
    logic        HALTED;
    logic        FAULT;

    logic [15:0] rom [256];

    int checks = 0;
    int errors = 0;

    logic [7:0] m_pc;
    logic [7:0] m_stack [$];
    bit         m_stop;
    bit         m_fault;

    fetch_ctrl #(.STACK_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .PC         (pc_bus),
        .instr      (instr),
        .ZERO       (ZERO),
        .EXEC_DONE  (EXEC_DONE),
        .addr       (addr),
        .LOAD_PC    (LOAD_PC),
        .INCR_PC    (INCR_PC),
        .IR         (IR),
        .EXEC_START (EXEC_START),
        .HALTED     (HALTED),
        .FAULT      (FAULT)
    );

    always #5 clk = ~clk;

    // Program counter and ROM environment around the controller
    always_ff @(posedge clk or posedge reset) begin
        if (reset) pc_bus <= 8'h00;
        else if (LOAD_PC) pc_bus <= addr;
        else if (INCR_PC) pc_bus <= pc_bus + 8'd1;
    end

    always_ff @(posedge clk) instr <= rom[pc_bus];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        EXEC_DONE = 1'b1;
        #1;
        chk("reset_outputs", {LOAD_PC, INCR_PC, EXEC_START, HALTED, FAULT, addr, IR}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        EXEC_DONE = 1'b0;
        m_pc = 8'h00;
        m_stack.delete();
        m_stop = 0;
        m_fault = 0;
    endtask

    // Runs one instruction from FETCH; k = EXEC cycles before DONE, zsel < 0 means random ZERO.
    task automatic run_instr(input int k, input int zsel);
        logic [15:0] op;
        logic [7:0]  t;
        logic [7:0]  nxt;
        logic [7:0]  exp_addr;
        logic        z;
        bit exp_load, exp_incr, exp_stop;
        int exp_cyc, exp_starts;
        int c, starts;
        bit bad;
        logic ld, inc, h;
        logic [7:0] a;
        op = rom[m_pc];
        t = op[7:0];
        z = (zsel < 0) ? 1'($urandom_range(0, 1)) : 1'(zsel);
        ZERO = z;
        exp_load = 0; exp_incr = 0; exp_stop = 0;
        exp_cyc = 3; exp_starts = 0; exp_addr = 8'h00;
        nxt = m_pc + 8'd1;
        case (op[15:12])
            4'h0: exp_incr = 1;
            4'h1: begin exp_load = 1; nxt = t; end
            4'h2: if (z) begin exp_load = 1; nxt = t; end else exp_incr = 1;
            4'h3: if (!z) begin exp_load = 1; nxt = t; end else exp_incr = 1;
            4'h4: begin
                if (m_stack.size() == DEPTH) begin exp_stop = 1; m_fault = 1; end
                else begin m_stack.push_back(m_pc + 8'd1); exp_load = 1; nxt = t; end
            end
            4'h5: begin
                if (m_stack.size() == 0) begin exp_stop = 1; m_fault = 1; end
                else begin nxt = m_stack.pop_back(); exp_load = 1; end
            end
            4'hF: exp_stop = 1;
            default: begin exp_incr = 1; exp_cyc = 4 + k; exp_starts = 1; end
        endcase
        if (exp_stop) exp_cyc = 4;
        if (exp_load) exp_addr = nxt;

        c = 1; starts = 0; bad = 0;
        ld = 0; inc = 0; h = 0; a = 8'h00;
        forever begin
            EXEC_DONE = (c <= 3) ? 1'($urandom_range(0, 1)) : (c == 4 + k);
            #1;
            if (c == 3) chk("ir", IR, op);
            if (EXEC_START) starts++;
            if (LOAD_PC && INCR_PC) bad = 1;
            if (!LOAD_PC && addr != 8'h00) bad = 1;
            if (LOAD_PC || INCR_PC || HALTED || c >= 40) begin
                ld = LOAD_PC; inc = INCR_PC; h = HALTED; a = addr;
                break;
            end
            @(negedge clk);
            c++;
        end
        chk("cycles", c, exp_cyc);
        chk("strobes", {ld, inc, h}, {exp_load, exp_incr, exp_stop});
        chk("addr", a, exp_addr);
        chk("exec_start", starts, exp_starts);
        chk("invariants", bad, 0);
        chk("fault", FAULT, m_fault);
        if (exp_stop) begin
            m_stop = 1;
            chk("pc_held", pc_bus, m_pc);
        end else begin
            @(negedge clk);
            EXEC_DONE = 1'b0;
            m_pc = nxt;
            chk("pc_next", pc_bus, m_pc);
        end
    endtask

    task automatic hold_stop(input int n);
        logic [12:0] e;
        e = {1'b1, 3'b000, m_fault, 8'h00};
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            EXEC_DONE = 1'($urandom_range(0, 1));
            #1;
            chk("stop_hold", {HALTED, LOAD_PC, INCR_PC, EXEC_START, FAULT, addr}, e);
            chk("stop_pc", pc_bus, m_pc);
        end
    endtask

    initial begin
        clear_rom();

        // NOP stream
        do_reset();
        for (int i = 0; i < 3; i++) run_instr(0, -1);

        // JMP
        rom[0] = 16'h1042;
        do_reset();
        run_instr(0, -1);

        // JZ / JNZ
        rom[0] = 16'h2010;
        do_reset();
        run_instr(0, 0);
        do_reset();
        run_instr(0, 1);
        rom[0] = 16'h3010;
        do_reset();
        run_instr(0, 1);

        // CALL / RET round trip
        clear_rom();
        rom[0] = 16'h1005; rom[8'h05] = 16'h4080; rom[8'h80] = 16'h5000;
        do_reset();
        for (int i = 0; i < 3; i++) run_instr(0, -1);

        // Return-address wrap: CALL at 0xFF returns to 0x00
        clear_rom();
        rom[0] = 16'h10FF; rom[8'hFF] = 16'h4010; rom[8'h10] = 16'h5000;
        do_reset();
        for (int i = 0; i < 3; i++) run_instr(0, -1);

        // Stack overflow on fifth nested CALL
        clear_rom();
        rom[8'h00] = 16'h4010; rom[8'h10] = 16'h4020; rom[8'h20] = 16'h4030;
        rom[8'h30] = 16'h4040; rom[8'h40] = 16'h4050;
        do_reset();
        for (int i = 0; i < 5; i++) run_instr(0, -1);
        hold_stop(4);

        // Underflow: RET right after reset
        rom[0] = 16'h5000;
        do_reset();
        run_instr(0, -1);
        hold_stop(2);

        // Execution handshake, late and immediate DONE
        clear_rom();
        rom[0] = 16'h7000;
        do_reset();
        run_instr(3, -1);
        do_reset();
        run_instr(0, -1);

        // HALT stays halted
        rom[0] = 16'hF000;
        do_reset();
        run_instr(0, -1);
        hold_stop(20);

        // Reset in the middle of EXEC
        rom[0] = 16'h7000;
        do_reset();
        for (int c = 1; c <= 4; c++) begin
            EXEC_DONE = 1'b0;
            #1;
            if (c == 4) chk("mid_exec_start", EXEC_START, 1);
            @(negedge clk);
        end
        do_reset();
        run_instr(2, -1);

        // Random programs
        for (int p = 0; p < 12; p++) begin
            for (int i = 0; i < 256; i++) begin
                logic [3:0] cls;
                cls = 4'($urandom_range(0, 13));
                if (cls > 4'd9) cls = 4'($urandom_range(4, 5));
                if ($urandom_range(0, 99) < 2) cls = 4'hF;
                rom[i] = {cls, 4'($urandom), 8'($urandom)};
            end
            do_reset();
            for (int n = 0; n < 50; n++) begin
                if (!m_stop) run_instr($urandom_range(0, 3), -1);
            end
            if (m_stop) hold_stop(3);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
